// File: rtl/ex_operand_forward.sv
// EX-stage operand resolution: registers ID codes/operands, converts stalls and flushes to bubbles.
// Latency: operands appear one cycle after the ID-stage codes; MEM/WB bypass values pass through combinationally.
// No backpressure: a load-use stall or a flush becomes an EX bubble, and the ID side holds its own state.
module ex_operand_forward #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_STALL  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            forward_data,
    input  logic [2:0]            forward_data2,
    input  logic [DATA_W-1:0]     rs1_data_id,
    input  logic [DATA_W-1:0]     rs2_data_id,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     alu_result_mem,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [DATA_W-1:0]     operand1_ex,
    output logic [DATA_W-1:0]     operand2_ex,
    output logic                  bubble_ex,
    output logic [CNT_W-1:0]      stall_events,
    output logic                  protocol_err
);

    // Wide enough to hold MAX_STALL+1 so an overrun is still visible once saturated.
    localparam int STALL_W = $clog2(MAX_STALL + 2);

    localparam logic [2:0] FWD_RS     = 3'b000;
    localparam logic [2:0] FWD_MEM    = 3'b001;
    localparam logic [2:0] FWD_ILL_A  = 3'b010;
    localparam logic [2:0] FWD_WB_ALU = 3'b011;
    localparam logic [2:0] FWD_ILL_B  = 3'b100;
    localparam logic [2:0] FWD_WB_LD  = 3'b101;
    localparam logic [2:0] FWD_RET    = 3'b110;
    localparam logic [2:0] FWD_STALL  = 3'b111;

    logic [2:0]        sel1_q, sel1_d;
    logic [2:0]        sel2_q, sel2_d;
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic [DATA_W-1:0] ret_data_q, ret_data_d;
    logic              bubble_q, bubble_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  stall_events_q, stall_events_d;
    logic              protocol_err_q, protocol_err_d;

    logic stall_req;
    logic illegal_sel;
    logic stall_overrun;

    function automatic logic is_illegal(input logic [2:0] code);
        return (code == FWD_ILL_A) || (code == FWD_ILL_B);
    endfunction

    // Codes 010/100 are undefined and fall back to the register-file value.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [2:0]        code,
        input logic [DATA_W-1:0] rs_val,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] ret_val
    );
        logic [DATA_W-1:0] res;
        res = rs_val;
        case (code)
            FWD_MEM:               res = mem_val;
            FWD_WB_ALU, FWD_WB_LD: res = wb_val;
            FWD_RET:               res = ret_val;
            default:               res = rs_val;
        endcase
        return res;
    endfunction

    // Next-state: flush beats stall beats normal capture; retire buffer and error flag update independently.
    always_comb begin
        sel1_d         = sel1_q;
        sel2_d         = sel2_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        bubble_d       = bubble_q;
        stall_cnt_d    = stall_cnt_q;
        stall_events_d = stall_events_q;
        protocol_err_d = protocol_err_q;

        stall_req     = (forward_data == FWD_STALL) || (forward_data2 == FWD_STALL);
        illegal_sel   = is_illegal(sel1_q) || is_illegal(sel2_q);
        stall_overrun = (stall_cnt_q >= STALL_W'(MAX_STALL));

        // An illegal code sitting in EX this cycle is reported at the coming edge.
        if (illegal_sel) begin
            protocol_err_d = 1'b1;
        end

        if (flush) begin
            sel1_d      = FWD_RS;
            sel2_d      = FWD_RS;
            rs1_d       = '0;
            rs2_d       = '0;
            bubble_d    = 1'b1;
            stall_cnt_d = '0;
        end else if (stall_req) begin
            sel1_d   = FWD_RS;
            sel2_d   = FWD_RS;
            rs1_d    = '0;
            rs2_d    = '0;
            bubble_d = 1'b1;
            if (stall_cnt_q != {STALL_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
            if (stall_events_q != {CNT_W{1'b1}}) begin
                stall_events_d = stall_events_q + CNT_W'(1);
            end
            // This stall cycle would push the run past the legal length.
            if (stall_overrun) begin
                protocol_err_d = 1'b1;
            end
        end else begin
            sel1_d      = forward_data;
            sel2_d      = forward_data2;
            rs1_d       = rs1_data_id;
            rs2_d       = rs2_data_id;
            bubble_d    = 1'b0;
            stall_cnt_d = '0;
        end

        // Writes to x0 are architecturally discarded, so they must not refresh the buffer.
        ret_data_d = ret_data_q;
        if (wb_reg_write && (wb_rd != '0)) begin
            ret_data_d = wb_data;
        end
    end

    // Pipeline and status registers; reset leaves EX holding a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel1_q         <= FWD_RS;
            sel2_q         <= FWD_RS;
            rs1_q          <= '0;
            rs2_q          <= '0;
            ret_data_q     <= '0;
            bubble_q       <= 1'b1;
            stall_cnt_q    <= '0;
            stall_events_q <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            sel1_q         <= sel1_d;
            sel2_q         <= sel2_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            ret_data_q     <= ret_data_d;
            bubble_q       <= bubble_d;
            stall_cnt_q    <= stall_cnt_d;
            stall_events_q <= stall_events_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Operand mux from registered selects; a bubble drives zeros so nothing leaks into the ALU.
    always_comb begin
        operand1_ex = '0;
        operand2_ex = '0;
        if (!bubble_q) begin
            operand1_ex = resolve(sel1_q, rs1_q, alu_result_mem, wb_data, ret_data_q);
            operand2_ex = resolve(sel2_q, rs2_q, alu_result_mem, wb_data, ret_data_q);
        end
    end

    assign bubble_ex    = bubble_q;
    assign stall_events = stall_events_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_ex_operand_forward.sv
// Bench for ex_operand_forward: directed vector table, multi-cycle corner sequences, randomized vs model.
// Every cycle starts at a falling edge: inputs driven, outputs sampled 1ns later, model advanced at the rising edge.
// Checks are counted in n_tests / n_fail and reported on one summary line.
module tb_ex_operand_forward;

    localparam int MAX_STALL = 1;

    logic        clk;
    logic        reset_n;
    logic [2:0]  forward_data;
    logic [2:0]  forward_data2;
    logic [31:0] rs1_data_id;
    logic [31:0] rs2_data_id;
    logic        flush;
    logic [31:0] alu_result_mem;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] operand1_ex;
    logic [31:0] operand2_ex;
    logic        bubble_ex;
    logic [15:0] stall_events;
    logic        protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    ex_operand_forward #(
        .DATA_W(32), .REG_ADDR_W(5), .MAX_STALL(MAX_STALL), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .forward_data(forward_data), .forward_data2(forward_data2),
        .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
        .flush(flush), .alu_result_mem(alu_result_mem),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .operand1_ex(operand1_ex), .operand2_ex(operand2_ex),
        .bubble_ex(bubble_ex), .stall_events(stall_events),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The instruction sitting in EX, described by what it will consume.
    typedef struct {
        bit          is_bubble;
        logic [2:0]  c1;
        logic [2:0]  c2;
        logic [31:0] d1;
        logic [31:0] d2;
    } ex_slot_t;

    ex_slot_t    m_ex;
    logic [31:0] m_ret;
    int          m_run;
    int          m_events;
    bit          m_err;

    task automatic model_reset();
        m_ex       = '{1'b1, 3'd0, 3'd0, 32'd0, 32'd0};
        m_ret      = 32'd0;
        m_run      = 0;
        m_events   = 0;
        m_err      = 1'b0;
    endtask

    function automatic logic [31:0] model_pick(input logic [2:0] c, input logic [31:0] d);
        if (c == 3'b001) return alu_result_mem;
        if (c == 3'b011 || c == 3'b101) return wb_data;
        if (c == 3'b110) return m_ret;
        return d;
    endfunction

    function automatic logic [31:0] model_op(input int which);
        if (m_ex.is_bubble) return 32'd0;
        return (which == 1) ? model_pick(m_ex.c1, m_ex.d1) : model_pick(m_ex.c2, m_ex.d2);
    endfunction

    task automatic model_edge();
        if (!m_ex.is_bubble && (m_ex.c1 inside {3'b010, 3'b100} || m_ex.c2 inside {3'b010, 3'b100}))
            m_err = 1'b1;
        if (flush) begin
            m_ex  = '{1'b1, 3'd0, 3'd0, 32'd0, 32'd0};
            m_run = 0;
        end else if (forward_data == 3'b111 || forward_data2 == 3'b111) begin
            m_ex  = '{1'b1, 3'd0, 3'd0, 32'd0, 32'd0};
            m_run = m_run + 1;
            if (m_run > MAX_STALL) m_err = 1'b1;
            if (m_events < 65535) m_events = m_events + 1;
        end else begin
            m_ex  = '{1'b0, forward_data, forward_data2, rs1_data_id, rs2_data_id};
            m_run = 0;
        end
        if (wb_reg_write && wb_rd != 5'd0) m_ret = wb_data;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] f1, input logic [2:0] f2,
                          input logic [31:0] r1, input logic [31:0] r2, input logic fl,
                          input logic [31:0] alu, input logic [31:0] wb,
                          input logic [4:0] rd, input logic we);
        forward_data   = f1;
        forward_data2  = f2;
        rs1_data_id    = r1;
        rs2_data_id    = r2;
        flush          = fl;
        alu_result_mem = alu;
        wb_data        = wb;
        wb_rd          = rd;
        wb_reg_write   = we;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  f1, f2;
        logic [31:0] rs1, rs2;
        logic        fl;
        logic [31:0] alu, wb;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] e_op1, e_op2;
        logic        e_bub;
        logic [15:0] e_ev;
        logic        e_err;
    } vec_t;

    vec_t vt [12];

    initial begin
        reset_n        = 1'b0;
        forward_data   = 3'd0;
        forward_data2  = 3'd0;
        rs1_data_id    = 32'd0;
        rs2_data_id    = 32'd0;
        flush          = 1'b0;
        alu_result_mem = 32'd0;
        wb_data        = 32'd0;
        wb_rd          = 5'd0;
        wb_reg_write   = 1'b0;

        // Inputs for this cycle | outputs expected during this cycle (from the previous edge).
        //          f1      f2      rs1     rs2    fl   alu       wb        rd  we    op1       op2     bub  ev  err
        vt[0]  = '{3'b000, 3'b000, 32'h5,  32'h7,  0, 32'h0,    32'h0,    5'd0, 0, 32'h0,    32'h0,    1, 16'd0, 0};
        vt[1]  = '{3'b001, 3'b011, 32'h9,  32'h9,  0, 32'h0,    32'h0,    5'd0, 0, 32'h5,    32'h7,    0, 16'd0, 0};
        vt[2]  = '{3'b111, 3'b000, 32'h0,  32'h0,  0, 32'h1234, 32'hAA,   5'd0, 0, 32'h1234, 32'hAA,   0, 16'd0, 0};
        vt[3]  = '{3'b101, 3'b000, 32'h1,  32'h2,  0, 32'h0,    32'h77,   5'd0, 0, 32'h0,    32'h0,    1, 16'd1, 0};
        vt[4]  = '{3'b000, 3'b000, 32'h3,  32'h4,  0, 32'h0,    32'hBEEF, 5'd0, 0, 32'hBEEF, 32'h2,    0, 16'd1, 0};
        vt[5]  = '{3'b000, 3'b110, 32'h11, 32'h22, 0, 32'h0,    32'h55,   5'd3, 1, 32'h3,    32'h4,    0, 16'd1, 0};
        vt[6]  = '{3'b000, 3'b000, 32'h33, 32'h44, 0, 32'h0,    32'h99,   5'd0, 1, 32'h11,   32'h55,   0, 16'd1, 0};
        vt[7]  = '{3'b111, 3'b111, 32'h0,  32'h0,  1, 32'h0,    32'h0,    5'd0, 0, 32'h33,   32'h44,   0, 16'd1, 0};
        vt[8]  = '{3'b111, 3'b000, 32'h0,  32'h0,  0, 32'h0,    32'h0,    5'd0, 0, 32'h0,    32'h0,    1, 16'd1, 0};
        vt[9]  = '{3'b111, 3'b000, 32'h0,  32'h0,  0, 32'h0,    32'h0,    5'd0, 0, 32'h0,    32'h0,    1, 16'd2, 0};
        vt[10] = '{3'b000, 3'b000, 32'h6,  32'h8,  0, 32'h0,    32'h0,    5'd0, 0, 32'h0,    32'h0,    1, 16'd3, 1};
        vt[11] = '{3'b000, 3'b000, 32'h0,  32'h0,  0, 32'h0,    32'h0,    5'd0, 0, 32'h6,    32'h8,    0, 16'd3, 1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            set_in(vt[i].f1, vt[i].f2, vt[i].rs1, vt[i].rs2, vt[i].fl,
                   vt[i].alu, vt[i].wb, vt[i].rd, vt[i].we);
            chk($sformatf("vec%0d op1", i), operand1_ex, vt[i].e_op1);
            chk($sformatf("vec%0d op2", i), operand2_ex, vt[i].e_op2);
            chk($sformatf("vec%0d bubble", i), {31'd0, bubble_ex}, {31'd0, vt[i].e_bub});
            chk($sformatf("vec%0d events", i), {16'd0, stall_events}, {16'd0, vt[i].e_ev});
            chk($sformatf("vec%0d err", i), {31'd0, protocol_err}, {31'd0, vt[i].e_err});
            advance();
        end

        // Illegal codes are passed through as register data and flagged one edge later.
        do_reset();
        set_in(3'b010, 3'b000, 32'hA, 32'hB, 0, 32'hF00, 32'hF11, 5'd0, 0);
        advance();
        set_in(3'b000, 3'b100, 32'hC, 32'hD, 0, 32'hF00, 32'hF11, 5'd0, 0);
        chk("ill op1 uses rs", operand1_ex, 32'hA);
        chk("ill op2", operand2_ex, 32'hB);
        chk("ill err not yet", {31'd0, protocol_err}, 32'd0);
        advance();
        set_in(3'b000, 3'b000, 32'h0, 32'h0, 0, 32'hF00, 32'hF11, 5'd0, 0);
        chk("ill err set", {31'd0, protocol_err}, 32'd1);
        chk("ill op2 uses rs", operand2_ex, 32'hD);
        advance();
        chk("ill err sticky", {31'd0, protocol_err}, 32'd1);

        // Reset in the middle of a stall must forget the run length.
        do_reset();
        set_in(3'b111, 3'b000, 32'h0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0);
        advance();
        reset_n = 1'b0;
        #1;
        chk("midrst bubble", {31'd0, bubble_ex}, 32'd1);
        chk("midrst events", {16'd0, stall_events}, 32'd0);
        chk("midrst err", {31'd0, protocol_err}, 32'd0);
        chk("midrst op1", operand1_ex, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        set_in(3'b000, 3'b111, 32'h0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0);
        chk("postrst bubble", {31'd0, bubble_ex}, 32'd1);
        advance();
        set_in(3'b000, 3'b000, 32'h5A, 32'h5B, 0, 32'h0, 32'h0, 5'd0, 0);
        chk("postrst events", {16'd0, stall_events}, 32'd1);
        chk("postrst err", {31'd0, protocol_err}, 32'd0);
        advance();
        set_in(3'b000, 3'b000, 32'h0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0);
        chk("postrst op1", operand1_ex, 32'h5A);
        chk("postrst err2", {31'd0, protocol_err}, 32'd0);
        advance();

        // Randomized traffic against the model, restarting from reset every block.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int cyc = 0; cyc < 50; cyc++) begin
                logic [2:0] c [2];
                for (int k = 0; k < 2; k++) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    if      (r < 30) c[k] = 3'b000;
                    else if (r < 45) c[k] = 3'b001;
                    else if (r < 58) c[k] = 3'b011;
                    else if (r < 70) c[k] = 3'b101;
                    else if (r < 84) c[k] = 3'b110;
                    else if (r < 96) c[k] = 3'b111;
                    else if (r < 98) c[k] = 3'b010;
                    else             c[k] = 3'b100;
                end
                set_in(c[0], c[1], $urandom, $urandom, ($urandom_range(0, 9) == 0),
                       $urandom, $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                chk("rand op1", operand1_ex, model_op(1));
                chk("rand op2", operand2_ex, model_op(2));
                chk("rand bubble", {31'd0, bubble_ex}, {31'd0, m_ex.is_bubble});
                chk("rand events", {16'd0, stall_events}, 32'(m_events));
                chk("rand err", {31'd0, protocol_err}, {31'd0, m_err});
                advance();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
